// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit that owns the Hi/Lo register pair.
//   Signed and unsigned MULT/DIV use one radix-2 step per cycle. Divide by zero
//   is flagged. A start/busy/done handshake lets the control FSM wait for the
//   result. Hi and Lo can also be written directly while the unit is idle.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   start, op         start request (sampled in IDLE); 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   op_a, op_b        multiplicand/dividend, multiplier/divisor
//   hi_we, lo_we      direct Hi/Lo write enables (IDLE only), data on wdata
//   busy, done        busy while not IDLE; done is a one-cycle completion pulse
//   divby0            valid with done: divide with op_b == 0
//   hi, lo            Hi/Lo registers (MULT: product high/low; DIV: remainder/quotient)
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             divby0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateType;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    stateType           state, stateNext;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         opReg;
    logic [WIDTH-1:0]   magA, magB;
    logic [2*WIDTH-1:0] acc;
    logic               negRes, negRem;
    logic               divby0Reg;
    logic [WIDTH-1:0]   hiReg, loReg;

    // Decode of the incoming request
    logic               startSigned, startDivZero;
    logic [WIDTH-1:0]   absA, absB;

    assign startSigned  = ~op[0];
    assign startDivZero = op[1] && (op_b == '0);
    assign absA = (startSigned && op_a[WIDTH-1]) ? -op_a : op_a;
    assign absB = (startSigned && op_b[WIDTH-1]) ? -op_b : op_b;

    // Multiply step: add multiplicand into the upper half (with carry), then shift right.
    logic [WIDTH:0]     mulSum;
    assign mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (magB[0] ? {1'b0, magA} : '0);

    // Restoring divide step: remainder lives in acc upper half, quotient in lower half,
    // dividend bits are fed in from the MSB of magA. The W-bit subtraction is exact
    // whenever divOk holds, because the true remainder is then below the divisor.
    logic [WIDTH:0]     divShift;
    logic [WIDTH-1:0]   remSub;
    logic               divOk;
    assign divShift = {acc[2*WIDTH-1:WIDTH], magA[WIDTH-1]};
    assign divOk    = divShift >= {1'b0, magB};
    assign remSub   = divShift[WIDTH-1:0] - magB;

    // Sign correction. MIN_INT / -1 wraps naturally: magnitude 2^(W-1) negated is itself.
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quotFix, remFix;
    assign prodFix = negRes ? -acc : acc;
    assign quotFix = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign remFix  = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (start) stateNext = startDivZero ? DONE : RUN;
            RUN:  if (cnt == LAST_STEP) stateNext = FIX;
            FIX:  stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            opReg     <= '0;
            magA      <= '0;
            magB      <= '0;
            acc       <= '0;
            negRes    <= 1'b0;
            negRem    <= 1'b0;
            divby0Reg <= 1'b0;
            hiReg     <= '0;
            loReg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hiReg <= wdata;
                    if (lo_we) loReg <= wdata;
                    if (start) begin
                        opReg     <= op;
                        magA      <= absA;
                        magB      <= absB;
                        negRes    <= startSigned && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        negRem    <= startSigned && op_a[WIDTH-1];
                        acc       <= '0;
                        cnt       <= '0;
                        divby0Reg <= startDivZero;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (opReg[1]) begin
                        magA <= magA << 1;
                        acc  <= {divOk ? remSub : divShift[WIDTH-1:0], acc[WIDTH-2:0], divOk};
                    end else begin
                        magB <= magB >> 1;
                        acc  <= {mulSum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (opReg[1]) begin
                        loReg <= quotFix;
                        hiReg <= remFix;
                    end else begin
                        {hiReg, loReg} <= prodFix;
                    end
                end
                DONE: divby0Reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign divby0 = divby0Reg;
    assign hi     = hiReg;
    assign lo     = loReg;

endmodule
